// File: rtl/adc_input_multi.sv
// adc_input_multi
// SPI reader for NUM_ADC AD7980-class converters. The converters share one
// chip-select and one serial clock, and each has its own DOUT line. The RHD2000
// command sequencer steps this block through main_state and channel.
//
// Features:
//   - in-order bit tracking with frame-error detection
//   - a registered parallel word output with a one-cycle valid strobe
//   - an optional per-converter threshold comparator
//
// Optional feature macro: ADC_THRESHOLD_EN
//   - defined:   ADC_above[i] is set when the published word i is greater than
//                threshold. The compare is signed when OFFSET_TO_TWOS=1.
//   - undefined: ADC_above is tied to zero and threshold is ignored.
module adc_input_multi #(
    parameter int          NUM_ADC        = 8,
    parameter int          ADC_BITS       = 16,
    parameter int          OFFSET_TO_TWOS = 0,
    parameter logic [31:0] ms_wait        = 32'd99,
    parameter logic [31:0] ms_clk1_a      = 32'd100,
    parameter logic [31:0] ms_clk11_a     = 32'd140
) (
    input  logic                          dataclk,
    input  logic                          reset,
    input  logic [31:0]                   main_state,
    input  logic [5:0]                    channel,
    input  logic [NUM_ADC-1:0]            ADC_DOUT,
    output logic                          ADC_CS,
    output logic                          ADC_SCLK,
    output logic [NUM_ADC*ADC_BITS-1:0]   ADC_data,
    output logic                          ADC_valid,
    output logic                          ADC_frame_err,
    input  logic [ADC_BITS-1:0]           threshold,
    output logic [NUM_ADC-1:0]            ADC_above
);

    // Last data channel of a frame (channel 0 only asserts CS).
    localparam logic [5:0] LAST_CH = 6'(ADC_BITS);

    typedef logic [ADC_BITS-1:0] word_t;

    // Converts a captured word into its published form.
    // Offset-binary becomes two's complement by flipping the MSB.
    function automatic word_t to_pub(input word_t w);
        word_t r;
        r = w;
        if (OFFSET_TO_TWOS != 0) begin
            r[ADC_BITS-1] = ~w[ADC_BITS-1];
        end
        return r;
    endfunction

    // Sequencer phase decode
    logic is_wait;
    logic is_clk1;
    logic is_clk11;

    assign is_wait  = (main_state == ms_wait);
    assign is_clk1  = (main_state == ms_clk1_a);
    assign is_clk11 = (main_state == ms_clk11_a);

    // Capture stage (p0) and published stage (p1)
    logic [NUM_ADC-1:0][ADC_BITS-1:0] cap_p0;
    logic [NUM_ADC-1:0][ADC_BITS-1:0] pub_p0;
    logic [NUM_ADC-1:0][ADC_BITS-1:0] data_p1;
    logic                             vld_p1;

    // Bus and frame-tracking control
    logic       cs_q;
    logic       sclk_q;
    logic       frame_err_q;
    logic [5:0] expect_ch;
    logic       complete;
    logic       err;

    // Capture bit addressed by the current channel: channel 1 is the MSB.
    logic [5:0] bit_idx;
    logic       data_ch;
    logic       publish_en;

    assign bit_idx    = LAST_CH - channel;
    assign data_ch    = (channel != 6'd0) && (channel <= LAST_CH);
    assign publish_en = is_clk11 && complete && !err;

    // Published form of each capture register
    always_comb begin
        pub_p0 = '0;
        for (int i = 0; i < NUM_ADC; i++) begin
            pub_p0[i] = to_pub(cap_p0[i]);
        end
    end

    // ---- stage p0: serial capture, driven by the SCLK-high phase ----
    // Shifts each converter's DOUT into the bit of its capture register
    // that the current channel addresses.
    always_ff @(posedge dataclk) begin
        if (reset) begin
            cap_p0 <= '0;
        end else if (is_clk1 && data_ch) begin
            for (int i = 0; i < NUM_ADC; i++) begin
                for (int b = 0; b < ADC_BITS; b++) begin
                    if (bit_idx == 6'(b)) begin
                        cap_p0[i][b] <= ADC_DOUT[i];
                    end
                end
            end
        end
    end

    // Bus-phase control and frame tracking
    // Drives CS and SCLK, checks that bits arrive in order, and detects
    // frames that were aborted before the last bit.
    always_ff @(posedge dataclk) begin
        if (reset) begin
            cs_q        <= 1'b1;
            sclk_q      <= 1'b0;
            frame_err_q <= 1'b0;
            expect_ch   <= 6'd0;
            complete    <= 1'b0;
            err         <= 1'b0;
        end else if (is_wait) begin
            cs_q   <= 1'b1;
            sclk_q <= 1'b0;
            // Bus idles with a frame still open: the frame was aborted.
            if ((expect_ch != 6'd0) && (expect_ch <= LAST_CH)) begin
                frame_err_q <= 1'b1;
                expect_ch   <= 6'd0;
            end
        end else if (is_clk1) begin
            if (channel == 6'd0) begin
                // Start of frame. A restart mid-frame is silent.
                cs_q      <= 1'b0;
                sclk_q    <= 1'b0;
                expect_ch <= 6'd1;
                complete  <= 1'b0;
                err       <= 1'b0;
            end else if (channel <= LAST_CH) begin
                cs_q   <= 1'b0;
                sclk_q <= 1'b1;
                if (channel == expect_ch) begin
                    expect_ch <= expect_ch + 6'd1;
                end else begin
                    err <= 1'b1;
                end
                // Any mismatch is already recorded in err; the publish
                // step decides between data and error.
                if (channel == LAST_CH) begin
                    complete <= 1'b1;
                end
            end else begin
                cs_q   <= 1'b1;
                sclk_q <= 1'b0;
            end
        end else if (is_clk11) begin
            sclk_q <= 1'b0;
            if (complete) begin
                complete    <= 1'b0;
                frame_err_q <= err;
            end
        end
    end

    // ---- stage p1: publish on the first SCLK-low phase after the last bit ----
    // Moves a clean frame into the output word with a one-cycle strobe.
    always_ff @(posedge dataclk) begin
        if (reset) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            if (publish_en) begin
                data_p1 <= pub_p0;
                vld_p1  <= 1'b1;
            end
        end
    end

    assign ADC_CS        = cs_q;
    assign ADC_SCLK      = sclk_q;
    assign ADC_data      = data_p1;
    assign ADC_valid     = vld_p1;
    assign ADC_frame_err = frame_err_q;

`ifdef ADC_THRESHOLD_EN
    // Greater-than compare. The compare is signed when words are published
    // as two's complement.
    function automatic logic is_above(input word_t w, input word_t t);
        if (OFFSET_TO_TWOS != 0) begin
            return $signed(w) > $signed(t);
        end
        return w > t;
    endfunction

    logic [NUM_ADC-1:0] above_p1;

    // Threshold flags, updated together with the published words
    always_ff @(posedge dataclk) begin
        if (reset) begin
            above_p1 <= '0;
        end else if (publish_en) begin
            for (int i = 0; i < NUM_ADC; i++) begin
                above_p1[i] <= is_above(pub_p0[i], threshold);
            end
        end
    end

    assign ADC_above = above_p1;
`else
    logic unused_threshold;

    assign unused_threshold = ^threshold;
    assign ADC_above        = '0;
`endif

endmodule
